// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues req/ack word reads, hands words to decode over valid/ready,
// applies branch redirects and counts deliveries. Define FETCH_TIMEOUT_EN for the memory-ack timeout.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        fetch_cnt,
  output logic              fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              mem_req_q, mem_req_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              waiting;
  logic              locked;
  logic              timeout_hit;

  // A read is outstanding in both REQ and DROP.
  assign waiting = (state_q == REQ) || (state_q == DROP);

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] tmo_q, tmo_d;

  // REQ->DROP keeps the same read outstanding, so the count carries across it.
  assign timeout_hit = waiting && !mem_ack && (tmo_q == TW'(TIMEOUT - 1));
  assign tmo_d       = (waiting && !mem_ack && !timeout_hit) ? tmo_q + TW'(1) : '0;
  assign locked      = err_q;
  assign err_d       = err_q | timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign timeout_hit = 1'b0;
  assign locked      = 1'b0;
  assign err_d       = 1'b0;
`endif

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable && !locked) state_d = REQ;
      REQ: begin
        if (mem_ack)           state_d = branch_valid ? REQ : HOLD;
        else if (branch_valid) state_d = DROP;
      end
      DROP: if (mem_ack) state_d = enable ? REQ : IDLE;
      HOLD: if (branch_valid || instr_ready) state_d = enable ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout_hit) state_d = IDLE;
  end

  always_comb begin
    pc_d       = branch_valid ? branch_target : pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      REQ: begin
        if (mem_ack && !branch_valid) begin
          instr_d    = mem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + ADDR_W'(1);
          valid_d    = 1'b1;
        end
      end
      HOLD: begin
        // A handshake coinciding with a branch still counts; the flush only drops valid.
        if (instr_ready)                 cnt_d   = cnt_q + 8'd1;
        if (instr_ready || branch_valid) valid_d = 1'b0;
      end
      default: ;
    endcase
    if (timeout_hit) valid_d = 1'b0;
    mem_req_d  = (state_d == REQ) || (state_d == DROP);
    // A fresh address is latched only when a new read starts, never mid-request.
    mem_addr_d = ((state_d == REQ) && ((state_q != REQ) || mem_ack)) ? pc_d : mem_addr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign fetch_cnt   = cnt_q;
  assign fetch_err   = err_q;

endmodule
